// File: rtl/reg_file_wb_ctrl.sv
// Register file write-port controller: post-reset init sweep of x1..x31,
// then round-robin arbitration of write-back requesters onto the port.
module reg_file_wb_ctrl #(
    parameter int NUM_REQ  = 3,
    parameter bit INIT_IDX = 1'b1,
    parameter int DATA_W   = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [5*NUM_REQ-1:0]        req_rd,
    input  logic [DATA_W*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        wb_hold,
    input  logic                        soft_init,
    output logic                        reg_write,
    output logic [4:0]                  rd_sel,
    output logic [DATA_W-1:0]           wb_data,
    output logic                        init_done
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    state_e              state_q;
    logic [4:0]          cnt_q;
    logic [PTR_W-1:0]    rr_ptr_q;
    logic                reg_write_q;
    logic [4:0]          rd_sel_q;
    logic [DATA_W-1:0]   wb_data_q;
    logic                init_done_q;

    logic                gnt_vld;
    logic [NUM_REQ-1:0]  gnt_oh;
    logic [PTR_W-1:0]    gnt_nxt;
    logic [4:0]          gnt_rd;
    logic [DATA_W-1:0]   gnt_data;
    logic                xfer;

    // Pass 0 covers indices at/after rr_ptr, pass 1 wraps around to the rest.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_oh   = '0;
        gnt_nxt  = '0;
        gnt_rd   = '0;
        gnt_data = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!gnt_vld && req_valid[i] &&
                    (p == 1 || PTR_W'(i) >= rr_ptr_q)) begin
                    gnt_vld   = 1'b1;
                    gnt_oh[i] = 1'b1;
                    gnt_nxt   = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
                    gnt_rd    = req_rd[5*i +: 5];
                    gnt_data  = req_data[DATA_W*i +: DATA_W];
                end
            end
        end
    end

    assign xfer      = (state_q == RUN) && !wb_hold && !soft_init && gnt_vld;
    assign req_ready = xfer ? gnt_oh : {NUM_REQ{1'b0}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT;
            cnt_q       <= 5'd1;
            rr_ptr_q    <= '0;
            reg_write_q <= 1'b0;
            rd_sel_q    <= '0;
            wb_data_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                INIT: begin
                    reg_write_q <= 1'b1;
                    rd_sel_q    <= cnt_q;
                    wb_data_q   <= INIT_IDX ? DATA_W'(cnt_q) : '0;
                    if (cnt_q == 5'd31) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                        cnt_q       <= 5'd1;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                RUN: begin
                    if (soft_init) begin
                        state_q     <= INIT;
                        cnt_q       <= 5'd1;
                        init_done_q <= 1'b0;
                        reg_write_q <= 1'b0;
                    end else if (xfer) begin
                        // rd=0 is consumed but never reaches the register file
                        reg_write_q <= (gnt_rd != 5'd0);
                        rd_sel_q    <= gnt_rd;
                        wb_data_q   <= gnt_data;
                        rr_ptr_q    <= gnt_nxt;
                    end else begin
                        reg_write_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign reg_write = reg_write_q;
    assign rd_sel    = rd_sel_q;
    assign wb_data   = wb_data_q;
    assign init_done = init_done_q;

endmodule
